// File: rtl/bram_seq_pkg.sv
// Shared types and helpers for the block-RAM sequential reader.
package bram_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Address increment that wraps at the RAM depth.
  function automatic int unsigned wrap_inc(input int unsigned a, input int unsigned depth);
    return (a + 32'd1 >= depth) ? 32'd0 : a + 32'd1;
  endfunction

endpackage

// File: rtl/bram_seq_reader_if.sv
// Load port, sweep control and tagged output stream of the sequential reader.
interface bram_seq_reader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic [ADDR_W-1:0] addr_out;
  logic              busy;
  logic              done;

  modport master (
    output wr_en, wr_addr, wr_data, start, stop, loop_en, base_addr, last_addr,
    input  data_out, data_valid, addr_out, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, loop_en, base_addr, last_addr,
    output data_out, data_valid, addr_out, busy, done
  );
endinterface

// File: rtl/sdp_bram.sv
// Read-first simple-dual-port RAM with one or two registered read stages.
module sdp_bram
  import bram_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] q_p0;

  // Writes ignore reset so the RAM can be loaded at any time.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Stage 0: array read; holds when no read is issued.
  always_ff @(posedge clk) begin
    if (reset)      q_p0 <= '0;
    else if (rd_en) q_p0 <= mem[rd_addr];
  end

  if (RD_LAT >= RD_LAT_MAX) begin : g_out_reg
    logic              en_p0;
    logic [DATA_W-1:0] q_p1;

    // Stage 1: optional output register, advanced only behind a real read.
    always_ff @(posedge clk) begin
      if (reset) begin
        en_p0 <= 1'b0;
        q_p1  <= '0;
      end else begin
        en_p0 <= rd_en;
        if (en_p0) q_p1 <= q_p0;
      end
    end

    assign rd_data = q_p1;
  end else begin : g_no_out_reg
    assign rd_data = q_p0;
  end

endmodule

// File: rtl/bram_seq_reader.sv
// Sweeps an internal RAM between latched base/last addresses, one word per cycle.
module bram_seq_reader
  import bram_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  bram_seq_reader_if.slave bus
);

  localparam int LAT = (RD_LAT >= RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT_MIN;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rd_addr, base_q, last_q;
  logic              issue, at_last, pipe_busy, accept;
  logic              busy, done;
  logic [LAT-1:0]    vld_p;
  logic [ADDR_W-1:0] tag_p [LAT];

  assign accept    = (state == IDLE) && bus.start && !bus.stop;
  assign issue     = (state == RUN) && !bus.stop;
  assign at_last   = (rd_addr == last_q);
  assign pipe_busy = |vld_p;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (bus.stop || (at_last && !bus.loop_en)) state_nxt = DRAIN;
      DRAIN:   if (!pipe_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN: busy = 1'b1;
      DRAIN: begin
        busy = pipe_busy;
        done = !pipe_busy;
      end
      default: ;
    endcase
  end

  // Window is latched once per sweep; the read pointer wraps to base on loop.
  always_ff @(posedge clk) begin
    if (accept) begin
      base_q  <= bus.base_addr;
      last_q  <= bus.last_addr;
      rd_addr <= bus.base_addr;
    end else if (issue) begin
      rd_addr <= at_last ? base_q : ADDR_W'(wrap_inc(32'(rd_addr), 2**ADDR_W));
    end
  end

  // Tag pipeline: valid and issue address travel alongside the RAM read stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p <= '0;
      for (int i = 0; i < LAT; i++) tag_p[i] <= '0;
    end else begin
      vld_p[0] <= issue;
      tag_p[0] <= rd_addr;
      for (int i = 1; i < LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
        tag_p[i] <= tag_p[i-1];
      end
    end
  end

  sdp_bram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .RD_LAT(LAT)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_en   (issue),
    .rd_addr (rd_addr),
    .rd_data (bus.data_out)
  );

  assign bus.data_valid = vld_p[LAT-1];
  assign bus.addr_out   = tag_p[LAT-1];
  assign bus.busy       = busy;
  assign bus.done       = done;

endmodule

// File: tb/tb_bram_seq_reader.sv
// Drives identical stimulus into RD_LAT=1 and RD_LAT=2 instances and checks both.
module tb_bram_seq_reader;

  logic       clk = 1'b0;
  logic       reset, wr_en, start, stop, loop_en;
  logic [2:0] wr_addr, base_addr, last_addr;
  logic [7:0] wr_data;

  always #5 clk = ~clk;

  bram_seq_reader_if #(.DATA_W(8), .ADDR_W(3)) if0 ();
  bram_seq_reader_if #(.DATA_W(8), .ADDR_W(3)) if1 ();

  assign if0.wr_en = wr_en;         assign if1.wr_en = wr_en;
  assign if0.wr_addr = wr_addr;     assign if1.wr_addr = wr_addr;
  assign if0.wr_data = wr_data;     assign if1.wr_data = wr_data;
  assign if0.start = start;         assign if1.start = start;
  assign if0.stop = stop;           assign if1.stop = stop;
  assign if0.loop_en = loop_en;     assign if1.loop_en = loop_en;
  assign if0.base_addr = base_addr; assign if1.base_addr = base_addr;
  assign if0.last_addr = last_addr; assign if1.last_addr = last_addr;

  bram_seq_reader #(.DATA_W(8), .ADDR_W(3), .RD_LAT(1)) dut_lat1 (
    .clk(clk), .reset(reset), .bus(if0.slave));
  bram_seq_reader #(.DATA_W(8), .ADDR_W(3), .RD_LAT(2)) dut_lat2 (
    .clk(clk), .reset(reset), .bus(if1.slave));

  logic [7:0] d_out [2];
  logic [2:0] a_out [2];
  logic       d_vld [2];
  logic       b_out [2];
  logic       dn_out [2];
  assign d_out[0] = if0.data_out;    assign d_out[1] = if1.data_out;
  assign a_out[0] = if0.addr_out;    assign a_out[1] = if1.addr_out;
  assign d_vld[0] = if0.data_valid;  assign d_vld[1] = if1.data_valid;
  assign b_out[0] = if0.busy;        assign b_out[1] = if1.busy;
  assign dn_out[0] = if0.done;       assign dn_out[1] = if1.done;

  typedef struct {
    logic [2:0] base;
    logic [2:0] last;
    bit         loop;
    int         stop_cyc;
    int         xstart_cyc;
    int         wr_cyc;
    logic [2:0] wa;
    logic [7:0] wd;
    int         exp_beats;
    logic [7:0] exp_last_data;
  } vec_t;

  vec_t       tbl [7];
  logic [7:0] mdl [8];
  int         checks = 0;
  int         errors = 0;
  int         lats [2] = '{1, 2};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sweep(input vec_t v, input int idx);
    logic [2:0] ea [$];
    logic [7:0] ed [$];
    logic [2:0] a;
    int nb [2], first [2], lastc [2], dcnt [2], dcyc [2];
    logic [7:0] lastd [2];
    bit fin;
    int cyc;
    a = v.base;
    forever begin
      ea.push_back(a);
      ed.push_back(mdl[a]);
      if (v.loop) begin
        if (ea.size() == v.stop_cyc - 1) break;
        a = (a == v.last) ? v.base : 3'(a + 3'd1);
      end else begin
        if (a == v.last) break;
        a = 3'(a + 3'd1);
      end
    end
    for (int d = 0; d < 2; d++) begin
      nb[d] = 0; first[d] = -1; lastc[d] = -1; dcnt[d] = 0; dcyc[d] = -1; lastd[d] = 8'h00;
    end
    @(negedge clk);
    base_addr = v.base; last_addr = v.last; loop_en = v.loop; start = 1'b1;
    fin = 1'b0;
    cyc = 0;
    while (!fin && cyc < 60) begin
      @(negedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
        if (cyc == 1) chk($sformatf("v%0d lat%0d busy_run", idx, lats[d]), b_out[d], 1);
        if (d_vld[d]) begin
          if (first[d] < 0) first[d] = cyc;
          lastc[d] = cyc;
          lastd[d] = d_out[d];
          if (nb[d] < ea.size()) begin
            chk($sformatf("v%0d lat%0d beat%0d addr", idx, lats[d], nb[d]), a_out[d], ea[nb[d]]);
            chk($sformatf("v%0d lat%0d beat%0d data", idx, lats[d], nb[d]), d_out[d], ed[nb[d]]);
          end
          nb[d]++;
        end
        if (dn_out[d]) begin
          dcnt[d]++;
          dcyc[d] = cyc;
          chk($sformatf("v%0d lat%0d busy_at_done", idx, lats[d]), b_out[d], 0);
        end
      end
      start = (cyc == v.xstart_cyc);
      if (cyc == v.xstart_cyc) begin base_addr = 3'd0; last_addr = 3'd7; end
      stop = (cyc == v.stop_cyc);
      wr_en = (cyc == v.wr_cyc);
      if (cyc == v.wr_cyc) begin wr_addr = v.wa; wr_data = v.wd; mdl[v.wa] = v.wd; end
      if (dcnt[0] > 0 && dcnt[1] > 0 && cyc >= dcyc[0] + 3 && cyc >= dcyc[1] + 3) fin = 1'b1;
    end
    chk($sformatf("v%0d timeout", idx), fin, 1);
    loop_en = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("v%0d lat%0d beats", idx, lats[d]), nb[d], v.exp_beats);
      chk($sformatf("v%0d lat%0d last_data", idx, lats[d]), lastd[d], v.exp_last_data);
      chk($sformatf("v%0d lat%0d first_cyc", idx, lats[d]), first[d], 1 + lats[d]);
      chk($sformatf("v%0d lat%0d last_cyc", idx, lats[d]), lastc[d], v.exp_beats + lats[d]);
      chk($sformatf("v%0d lat%0d done_cnt", idx, lats[d]), dcnt[d], 1);
      chk($sformatf("v%0d lat%0d done_cyc", idx, lats[d]), dcyc[d], v.exp_beats + 1 + lats[d]);
      chk($sformatf("v%0d lat%0d busy_after", idx, lats[d]), b_out[d], 0);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s lat%0d data_out", tag, lats[d]), d_out[d], 0);
      chk($sformatf("%s lat%0d data_valid", tag, lats[d]), d_vld[d], 0);
      chk($sformatf("%s lat%0d addr_out", tag, lats[d]), a_out[d], 0);
      chk($sformatf("%s lat%0d busy", tag, lats[d]), b_out[d], 0);
      chk($sformatf("%s lat%0d done", tag, lats[d]), dn_out[d], 0);
    end
  endtask

  initial begin
    //         base  last  loop stop xst  wr   wa    wd      beats last_data
    tbl[0] = '{3'd0, 3'd7, 1'b0, 0,  0,   0,   3'd0, 8'h00,  8,    8'h17};
    tbl[1] = '{3'd6, 3'd1, 1'b0, 0,  0,   0,   3'd0, 8'h00,  4,    8'h11};
    tbl[2] = '{3'd2, 3'd4, 1'b1, 11, 0,   0,   3'd0, 8'h00,  10,   8'h12};
    tbl[3] = '{3'd5, 3'd5, 1'b0, 0,  2,   0,   3'd0, 8'h00,  1,    8'h15};
    tbl[4] = '{3'd0, 3'd7, 1'b0, 0,  0,   4,   3'd3, 8'hAA,  8,    8'h17};
    tbl[5] = '{3'd2, 3'd4, 1'b0, 0,  0,   0,   3'd0, 8'h00,  3,    8'h14};
    tbl[6] = '{3'd0, 3'd7, 1'b0, 0,  0,   0,   3'd0, 8'h00,  8,    8'h17};

    reset = 1'b1; wr_en = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    wr_addr = '0; wr_data = '0; base_addr = '0; last_addr = '0;

    // Load the RAM while reset is held: writes must still land.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 8'(8'h10 + i); mdl[i] = 8'(8'h10 + i);
    end
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    chk_outputs_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // start together with stop must be ignored.
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    chk("start_with_stop lat1 busy", b_out[0], 0);
    chk("start_with_stop lat2 busy", b_out[1], 0);

    for (int i = 0; i < 6; i++) sweep(tbl[i], i);

    // Reset mid-sweep: outputs clear on the next edge, no done follows.
    @(negedge clk);
    base_addr = 3'd0; last_addr = 3'd7; start = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_reset lat1 valid", d_vld[0], 1);
    chk("pre_reset lat2 valid", d_vld[1], 1);
    reset = 1'b1;
    @(negedge clk);
    chk_outputs_zero("midreset");
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("post_reset c%0d lat%0d done", c, lats[d]), dn_out[d], 0);
        chk($sformatf("post_reset c%0d lat%0d busy", c, lats[d]), b_out[d], 0);
      end
    end

    sweep(tbl[6], 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
